// File: rtl/mic1_seq_shifter_if.sv
// Request/result handshake bundle for mic1_seq_shifter.
// The shifter connects as slave; the producer/consumer side uses master.
interface mic1_seq_shifter_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_n;
    logic             out_z;

    modport master (
        output in_valid, in_data, in_op, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_n, out_z
    );

    modport slave (
        input  in_valid, in_data, in_op, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_n, out_z
    );
endinterface

// File: rtl/mic1_seq_shifter.sv
// Multi-cycle MIC-1 shifter: STEP bits per cycle, valid/ready on both sides, N/Z flags.
// Define SHIFTER_ROTATE_EN to turn op=11 from logical shift right into rotate right.
module mic1_seq_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    mic1_seq_shifter_if.slave   bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1;
    localparam logic [AMT_W-1:0] WidthW = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] StepW  = AMT_W'(STEP);

    localparam logic [1:0] OpPass = 2'b00;
    localparam logic [1:0] OpSll  = 2'b01;
    localparam logic [1:0] OpSra  = 2'b10;
    localparam logic [1:0] OpSrl  = 2'b11;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_n_q, out_n_d;
    logic             out_z_q, out_z_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [AMT_W-1:0] eff;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] shift_res;

    // Effective amount: saturate at WIDTH for shifts, wrap modulo WIDTH for rotate.
    always_comb begin
        eff = (bus.in_amt > WidthW) ? WidthW : bus.in_amt;
`ifdef SHIFTER_ROTATE_EN
        if (bus.in_op == OpSrl) begin
            eff = bus.in_amt % WidthW;
        end
`endif
    end

    always_comb begin
        step_amt  = (rem_q > StepW) ? StepW : rem_q;
        shift_res = data_q;
        case (op_q)
            OpSll:   shift_res = data_q << step_amt;
            OpSra:   shift_res = $unsigned($signed(data_q) >>> step_amt);
`ifdef SHIFTER_ROTATE_EN
            OpSrl:   shift_res = (data_q >> step_amt) | (data_q << (WidthW - step_amt));
`else
            OpSrl:   shift_res = data_q >> step_amt;
`endif
            default: shift_res = data_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        op_d       = op_q;
        rem_d      = rem_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d = bus.in_data;
                    op_d   = bus.in_op;
                    if (bus.in_op == OpPass || eff == '0) begin
                        rem_d      = '0;
                        out_data_d = bus.in_data;
                        state_d    = StDone;
                    end else begin
                        rem_d   = eff;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                data_d = shift_res;
                rem_d  = rem_q - step_amt;
                if (rem_d == '0) begin
                    out_data_d = shift_res;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Result register only changes on entry to DONE, so flags track the final value.
        out_n_d     = out_data_d[WIDTH-1];
        out_z_d     = (out_data_d == '0);
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            op_q        <= OpPass;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_n_q     <= 1'b0;
            out_z_q     <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_n_q     <= out_n_d;
            out_z_q     <= out_z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_n     = out_n_q;
    assign bus.out_z     = out_z_q;
endmodule

// File: tb/tb_mic1_seq_shifter.sv
// Directed bench for mic1_seq_shifter: WIDTH=32 with STEP=1 and STEP=4 instances.
// Expected op=11 results follow SHIFTER_ROTATE_EN when it is defined for the build.
module tb_mic1_seq_shifter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mic1_seq_shifter_if #(.WIDTH(32)) bus ();
    mic1_seq_shifter_if #(.WIDTH(32)) bus4 ();

    mic1_seq_shifter #(.WIDTH(32), .STEP(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    mic1_seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on the STEP=1 instance and collect its result; lat=-1 on timeout.
    task automatic do_op(input logic [31:0] d, input logic [1:0] op, input logic [5:0] amt,
                         output int lat, output logic [31:0] res, output logic n,
                         output logic z);
        int guard;
        bus.in_data   = d;
        bus.in_op     = op;
        bus.in_amt    = amt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        res = bus.out_data;
        n   = bus.out_n;
        z   = bus.out_z;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        checks++;
        if (bus.out_n !== 1'b0 || bus.out_z !== 1'b1) begin
            errors++; $display("FAIL reset_flags: got n=%b z=%b expected n=0 z=1",
                               bus.out_n, bus.out_z);
        end
    endtask

    task automatic test_shift_vectors;
        logic [31:0] v_d   [6];
        logic [1:0]  v_op  [6];
        logic [5:0]  v_amt [6];
        logic [31:0] v_res [6];
        int          v_lat [6];
        int          lat;
        logic [31:0] res;
        logic        n, z;
        // SLL8, SRA1, SRA saturate, SLL by WIDTH, eff=0, SLL1 of a negative value
        v_d   = '{32'h0000_00FF, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001,
                  32'h0000_00A5, 32'hC000_0001};
        v_op  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
        v_amt = '{6'd8, 6'd1, 6'd40, 6'd32, 6'd0, 6'd1};
        v_res = '{32'h0000_FF00, 32'hC000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                  32'h0000_00A5, 32'h8000_0002};
        v_lat = '{9, 2, 33, 33, 1, 2};
        for (int i = 0; i < 6; i++) begin
            do_op(v_d[i], v_op[i], v_amt[i], lat, res, n, z);
            checks++;
            if (res !== v_res[i]) begin
                errors++; $display("FAIL shift_data[%0d]: got %h expected %h", i, res, v_res[i]);
            end
            checks++;
            if (lat != v_lat[i]) begin
                errors++; $display("FAIL shift_latency[%0d]: got %0d expected %0d",
                                   i, lat, v_lat[i]);
            end
            checks++;
            if (n !== v_res[i][31] || z !== (v_res[i] == 32'h0)) begin
                errors++; $display("FAIL shift_flags[%0d]: got n=%b z=%b expected n=%b z=%b",
                                   i, n, z, v_res[i][31], v_res[i] == 32'h0);
            end
        end
    endtask

    task automatic test_op11;
        int          lat;
        logic [31:0] res;
        logic        n, z;
        logic [31:0] exp_a, exp_b;
        int          lat_b;
`ifdef SHIFTER_ROTATE_EN
        exp_a = 32'h1000_0000;
        exp_b = 32'h1000_0000;
        lat_b = 5;
`else
        exp_a = 32'h0000_0000;
        exp_b = 32'h0000_0000;
        lat_b = 33;
`endif
        do_op(32'h0000_0001, 2'b11, 6'd4, lat, res, n, z);
        checks++;
        if (res !== exp_a || z !== (exp_a == 32'h0) || lat != 5) begin
            errors++; $display("FAIL op11_amt4: got %h z=%b lat=%0d expected %h z=%b lat=5",
                               res, z, lat, exp_a, exp_a == 32'h0);
        end
        do_op(32'h0000_0001, 2'b11, 6'd36, lat, res, n, z);
        checks++;
        if (res !== exp_b || lat != lat_b) begin
            errors++; $display("FAIL op11_amt36: got %h lat=%0d expected %h lat=%0d",
                               res, lat, exp_b, lat_b);
        end
    endtask

    task automatic test_pass_backpressure;
        int guard;
        bus.in_data   = 32'h1234_5678;
        bus.in_op     = 2'b00;
        bus.in_amt    = 6'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL pass_latency: got out_valid=%b expected 1", bus.out_valid);
        end
        bus.in_data = 32'hDEAD_BEEF;
        bus.in_op   = 2'b01;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678 ||
                bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL hold[%0d]: got v=%b d=%h rdy=%b expected v=1 d=12345678 rdy=0",
                                   i, bus.out_valid, bus.out_data, bus.in_ready);
            end
            @(negedge clk);
        end
        // Release and present the next request in the same cycle.
        bus.out_ready = 1'b1;
        bus.in_data   = 32'h0000_0001;
        bus.in_op     = 2'b01;
        bus.in_amt    = 6'd1;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL release_idle: got rdy=%b v=%b expected rdy=1 v=0",
                               bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL next_accept: got in_ready=%b expected 0", bus.in_ready);
        end
        guard = 1;
        while (bus.out_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.out_data !== 32'h0000_0002 || guard != 2) begin
            errors++; $display("FAIL next_result: got %h lat=%0d expected 00000002 lat=2",
                               bus.out_data, guard);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        bus.in_data  = 32'h0000_00FF;
        bus.in_op    = 2'b01;
        bus.in_amt   = 6'd20;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_shift: got v=%b rdy=%b expected v=0 rdy=0",
                               bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
            bus.out_z !== 1'b1) begin
            errors++; $display("FAIL abort_reset: got rdy=%b v=%b d=%h z=%b expected 1 0 0 1",
                               bus.in_ready, bus.out_valid, bus.out_data, bus.out_z);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_result: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_step4;
        logic [31:0] v_d   [3];
        logic [1:0]  v_op  [3];
        logic [5:0]  v_amt [3];
        logic [31:0] v_res [3];
        int          v_lat [3];
        int          lat;
        v_d   = '{32'h0000_00FF, 32'h0000_00FF, 32'h8000_0001};
        v_op  = '{2'b01, 2'b01, 2'b10};
        v_amt = '{6'd8, 6'd6, 6'd40};
        v_res = '{32'h0000_FF00, 32'h0000_3FC0, 32'hFFFF_FFFF};
        v_lat = '{3, 3, 9};
        for (int i = 0; i < 3; i++) begin
            bus4.in_data  = v_d[i];
            bus4.in_op    = v_op[i];
            bus4.in_amt   = v_amt[i];
            bus4.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus4.in_valid = 1'b0;
            lat = 1;
            while (bus4.out_valid !== 1'b1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (bus4.out_data !== v_res[i] || lat != v_lat[i]) begin
                errors++; $display("FAIL step4[%0d]: got %h lat=%0d expected %h lat=%0d",
                                   i, bus4.out_data, lat, v_res[i], v_lat[i]);
            end
            bus4.out_ready = 1'b1;
            @(negedge clk);
            bus4.out_ready = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_op      = '0;
        bus.in_amt     = '0;
        bus.out_ready  = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_op     = '0;
        bus4.in_amt    = '0;
        bus4.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_shift_vectors();
        test_op11();
        test_pass_backpressure();
        test_reset_mid_shift();
        test_step4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
